kypd_entry_buffer: RTL and testbench

KYPD_ENTRY_BUFFER -- requirements
Module: kypd_entry_buffer

---
 rtl/kypd_pkg.sv | 19 +
 rtl/kypd_debounce.sv | 117 +++++++++++
 rtl/kypd_entry_buffer.sv | 116 +++++++++++
 tb/tb_kypd_entry_buffer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kypd_pkg.sv
// Shared keypad constants, FSM encoding and helpers.
// Imported by kypd_debounce and kypd_entry_buffer.
package kypd_pkg;

  localparam logic [3:0] KEY_CLEAR = 4'hE;
  localparam logic [3:0] KEY_ENTER = 4'hF;

  localparam int DEBOUNCE_DEFAULT = 200000;

  typedef enum logic {
    S_EDIT  = 1'b0,
    S_OFFER = 1'b1
  } state_e;

  function automatic logic is_digit(input logic [3:0] c);
    return c < KEY_CLEAR;
  endfunction

endpackage

// File: rtl/kypd_debounce.sv
// Key code synchronizer, debounce counter and baseline capture.
// Ports: clk, rst_n (async low), key_code in; key_acc, key_strobe, key_last out.
// Counter present only when KYPD_DEBOUNCE_EN is defined.
module kypd_debounce
  import kypd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_code,
  output logic [3:0] key_acc,
  output logic       key_strobe,
  output logic [3:0] key_last
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
    $error("DEBOUNCE_CYCLES must be >= 1");
  end

  // vld_q marks when s2_q holds a real sample, not reset fill
`ifdef KYPD_DEBOUNCE_EN
  localparam int VW = 3;
  localparam int CW = (DEBOUNCE_CYCLES > 1) ?
                      $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(DEBOUNCE_CYCLES - 1);
`else
  localparam int VW = 2;
`endif

  logic [3:0]    s1_q, s1_d;
  logic [3:0]    s2_q, s2_d;
  logic [VW-1:0] vld_q, vld_d;
  logic          base_q, base_d;
  logic [3:0]    acc_q, acc_d;
  logic [3:0]    last_q, last_d;
  logic          strb_q, strb_d;
`ifdef KYPD_DEBOUNCE_EN
  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    s1_d   = key_code;
    s2_d   = s1_q;
    vld_d  = {vld_q[VW-2:0], 1'b1};
    base_d = base_q;
    acc_d  = acc_q;
    last_d = last_q;
    strb_d = 1'b0;
`ifdef KYPD_DEBOUNCE_EN
    cand_d = cand_q;
    cnt_d  = cnt_q;
    // cnt_q == k means k+1 identical samples of cand_q seen
    if (!vld_q[VW-1]) begin
      cand_d = s2_q;
      cnt_d  = '0;
    end else if (s2_q != cand_q) begin
      cand_d = s2_q;
      cnt_d  = '0;
    end else if (cnt_q != CNT_TOP) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!base_q) begin
      base_d = 1'b1;
      acc_d  = cand_q;
    end else if (cand_q != acc_q) begin
      acc_d  = cand_q;
      last_d = cand_q;
      strb_d = 1'b1;
    end
`else
    if (vld_q[VW-1]) begin
      if (!base_q) begin
        base_d = 1'b1;
        acc_d  = s2_q;
      end else if (s2_q != acc_q) begin
        acc_d  = s2_q;
        last_d = s2_q;
        strb_d = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      vld_q  <= '0;
      base_q <= 1'b0;
      acc_q  <= '0;
      last_q <= '0;
      strb_q <= 1'b0;
`ifdef KYPD_DEBOUNCE_EN
      cand_q <= '0;
      cnt_q  <= '0;
`endif
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      vld_q  <= vld_d;
      base_q <= base_d;
      acc_q  <= acc_d;
      last_q <= last_d;
      strb_q <= strb_d;
`ifdef KYPD_DEBOUNCE_EN
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
`endif
    end
  end

  assign key_acc    = acc_q;
  assign key_strobe = strb_q;
  assign key_last   = last_q;

endmodule

// File: rtl/kypd_entry_buffer.sv
// Keypad hex entry buffer: edit, commit and valid/ready offer.
// Ports: clk, rst_n, key_code, out_ready in; key_strobe, key_last,
// entry_value, entry_count, overflow, out_data, out_valid out.
// Debounce enabled by defining KYPD_DEBOUNCE_EN.
module kypd_entry_buffer
  import kypd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int NUM_DIGITS      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [3:0]              key_code,
  output logic                    key_strobe,
  output logic [3:0]              key_last,
  output logic [4*NUM_DIGITS-1:0] entry_value,
  output logic [2:0]              entry_count,
  output logic                    overflow,
  output logic [4*NUM_DIGITS-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int W = 4 * NUM_DIGITS;

  if (NUM_DIGITS < 1 || NUM_DIGITS > 7) begin : g_bad_digits
    $error("NUM_DIGITS must be 1..7");
  end

  logic [3:0] key_acc;

  kypd_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_code   (key_code),
    .key_acc    (key_acc),
    .key_strobe (key_strobe),
    .key_last   (key_last)
  );

  state_e         state_q, state_d;
  logic [W-1:0]   entry_q, entry_d;
  logic [2:0]     cnt_q, cnt_d;
  logic           ovf_q, ovf_d;
  logic [W-1:0]   odata_q, odata_d;
  logic           full;

  assign full = (cnt_q == 3'(NUM_DIGITS));

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    odata_d = odata_q;
    unique case (state_q)
      S_EDIT: begin
        if (key_strobe) begin
          unique case (1'b1)
            key_acc == KEY_CLEAR: begin
              entry_d = '0;
              cnt_d   = '0;
              ovf_d   = 1'b0;
            end
            key_acc == KEY_ENTER: begin
              if (cnt_q != 3'd0) begin
                odata_d = entry_q;
                entry_d = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
                state_d = S_OFFER;
              end
            end
            is_digit(key_acc) && full: begin
              ovf_d = 1'b1;
            end
            default: begin
              entry_d = (entry_q << 4) | W'(key_acc);
              cnt_d   = cnt_q + 3'd1;
            end
          endcase
        end
      end
      S_OFFER: begin
        // key events are dropped while an offer is pending
        if (out_ready) state_d = S_EDIT;
      end
      default: state_d = S_EDIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EDIT;
      entry_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      odata_q <= '0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      odata_q <= odata_d;
    end
  end

  assign entry_value = entry_q;
  assign entry_count = cnt_q;
  assign overflow    = ovf_q;
  assign out_data    = odata_q;
  assign out_valid   = (state_q == S_OFFER);

endmodule

// File: tb/tb_kypd_entry_buffer.sv
// Self-checking bench for kypd_entry_buffer (DEBOUNCE_CYCLES=4, NUM_DIGITS=4).
// Vector table, corner sequences and random stimulus against a window model.
module tb_kypd_entry_buffer;

  localparam int DCYC = 4;
  localparam int NDIG = 4;
`ifdef KYPD_DEBOUNCE_EN
  localparam int DEFF = DCYC;
  localparam int LAT  = 2 + DCYC + 1;
`else
  localparam int DEFF = 0;
  localparam int LAT  = 3;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  key_code;
  logic        key_strobe;
  logic [3:0]  key_last;
  logic [15:0] entry_value;
  logic [2:0]  entry_count;
  logic        overflow;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  kypd_entry_buffer #(
    .DEBOUNCE_CYCLES(DCYC),
    .NUM_DIGITS(NDIG)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_code    (key_code),
    .key_strobe  (key_strobe),
    .key_last    (key_last),
    .entry_value (entry_value),
    .entry_count (entry_count),
    .overflow    (overflow),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  // reference model: event when the last DEFF+1 synchronized samples agree
  int         m_n;
  logic [3:0] hist[$];
  bit         m_base;
  logic [3:0] m_acc;
  logic [3:0] m_last;
  bit         m_strobe;
  int         m_buf;
  int         m_cnt;
  bit         m_ovf;
  bit         m_offer;
  int         m_odata;
  int         m_strobes = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_n = 0;
    hist.delete();
    m_base = 0;
    m_acc = 0;
    m_last = 0;
    m_strobe = 0;
    m_buf = 0;
    m_cnt = 0;
    m_ovf = 0;
    m_offer = 0;
    m_odata = 0;
  endtask

  task automatic model_edge();
    int lo, hi;
    bit st;
    logic [3:0] v, c;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (m_offer) begin
        if (out_ready) m_offer = 0;
      end else if (m_strobe) begin
        c = m_last;
        if (c == 4'hE) begin
          m_buf = 0; m_cnt = 0; m_ovf = 0;
        end else if (c == 4'hF) begin
          if (m_cnt > 0) begin
            m_odata = m_buf; m_offer = 1;
            m_buf = 0; m_cnt = 0; m_ovf = 0;
          end
        end else if (m_cnt < NDIG) begin
          m_buf = m_buf * 16 + int'(c);
          m_cnt++;
        end else begin
          m_ovf = 1;
        end
      end
      m_n++;
      hist.push_back(key_code);
      m_strobe = 0;
      hi = m_n - 2;
      lo = hi - DEFF;
      if (lo >= 1) begin
        st = 1;
        v = hist[hi-1];
        for (int i = lo; i <= hi; i++)
          if (hist[i-1] != v) st = 0;
        if (st) begin
          if (!m_base) begin
            m_base = 1;
            m_acc = v;
          end else if (v != m_acc) begin
            m_acc = v;
            m_last = v;
            m_strobe = 1;
            m_strobes++;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    chk("key_strobe", 32'(key_strobe), 32'(m_strobe));
    chk("key_last", 32'(key_last), 32'(m_last));
    chk("entry_value", 32'(entry_value), m_buf);
    chk("entry_count", 32'(entry_count), m_cnt);
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("out_valid", 32'(out_valid), 32'(m_offer));
    chk("out_data", 32'(out_data), m_odata);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic hold(input logic [3:0] k, input int n);
    key_code = k;
    repeat (n) tick();
  endtask

  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    #1 model_reset();
    chk("rst_strobe", 32'(key_strobe), 0);
    chk("rst_last", 32'(key_last), 0);
    chk("rst_value", 32'(entry_value), 0);
    chk("rst_count", 32'(entry_count), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_odata", 32'(out_data), 0);
    chk("rst_valid", 32'(out_valid), 0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic measure(input logic [3:0] code, input string nm);
    int lat, n;
    lat = -1;
    n = 0;
    key_code = code;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (key_strobe) begin
        n++;
        if (lat < 0) lat = i;
      end
    end
    chk({nm, "_latency"}, lat, LAT);
    chk({nm, "_strobes"}, n, 1);
    chk({nm, "_last"}, 32'(key_last), 32'(code));
  endtask

  typedef struct {
    logic [3:0]  key;
    int          n;
    bit          rdy;
    int          cnt;
    logic [15:0] val;
    bit          ovf;
    bit          vld;
    logic [15:0] odata;
    logic [3:0]  last;
  } vec_t;

  vec_t vt[$];

  initial begin
    int ds, s0, nv;
    rst_n = 1'b0;
    key_code = 4'h0;
    out_ready = 1'b0;
    model_reset();

    vt.push_back('{4'h0, 10, 0, 0, 16'h0000, 0, 0, 16'h0000, 4'h0});
    vt.push_back('{4'h1, 10, 0, 1, 16'h0001, 0, 0, 16'h0000, 4'h1});
    vt.push_back('{4'h2, 10, 0, 2, 16'h0012, 0, 0, 16'h0000, 4'h2});
    vt.push_back('{4'h3, 10, 0, 3, 16'h0123, 0, 0, 16'h0000, 4'h3});
    vt.push_back('{4'hF, 10, 0, 0, 16'h0000, 0, 1, 16'h0123, 4'hF});
    vt.push_back('{4'h7, 10, 0, 0, 16'h0000, 0, 1, 16'h0123, 4'h7});
    vt.push_back('{4'h8, 10, 0, 0, 16'h0000, 0, 1, 16'h0123, 4'h8});
    vt.push_back('{4'h8, 1,  1, 0, 16'h0000, 0, 0, 16'h0123, 4'h8});
    vt.push_back('{4'h1, 10, 0, 1, 16'h0001, 0, 0, 16'h0123, 4'h1});
    vt.push_back('{4'h2, 10, 0, 2, 16'h0012, 0, 0, 16'h0123, 4'h2});
    vt.push_back('{4'h3, 10, 0, 3, 16'h0123, 0, 0, 16'h0123, 4'h3});
    vt.push_back('{4'h4, 10, 0, 4, 16'h1234, 0, 0, 16'h0123, 4'h4});
    vt.push_back('{4'h5, 10, 0, 4, 16'h1234, 1, 0, 16'h0123, 4'h5});
    vt.push_back('{4'hE, 10, 0, 0, 16'h0000, 0, 0, 16'h0123, 4'hE});
    vt.push_back('{4'h4, 10, 0, 1, 16'h0004, 0, 0, 16'h0123, 4'h4});
    vt.push_back('{4'h2, 10, 0, 2, 16'h0042, 0, 0, 16'h0123, 4'h2});
    vt.push_back('{4'hF, 10, 0, 0, 16'h0000, 0, 1, 16'h0042, 4'hF});
    vt.push_back('{4'h7, 10, 0, 0, 16'h0000, 0, 1, 16'h0042, 4'h7});
    vt.push_back('{4'h8, 10, 0, 0, 16'h0000, 0, 1, 16'h0042, 4'h8});
    vt.push_back('{4'h8, 1,  1, 0, 16'h0000, 0, 0, 16'h0042, 4'h8});

    repeat (3) tick();
    chk("reset_valid", 32'(out_valid), 0);
    chk("reset_value", 32'(entry_value), 0);
    chk("reset_last", 32'(key_last), 0);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      out_ready = vt[i].rdy;
      hold(vt[i].key, vt[i].n);
      chk($sformatf("vec%0d_count", i), 32'(entry_count), vt[i].cnt);
      chk($sformatf("vec%0d_value", i), 32'(entry_value), 32'(vt[i].val));
      chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vt[i].ovf));
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vt[i].vld));
      chk($sformatf("vec%0d_odata", i), 32'(out_data), 32'(vt[i].odata));
      chk($sformatf("vec%0d_last", i), 32'(key_last), 32'(vt[i].last));
    end
    out_ready = 1'b0;

    // bouncing input: 6/5 alternating every 2 cycles, then settle on 6
    ds = 0;
    s0 = m_strobes;
    for (int p = 0; p < 10; p++) begin
      key_code = p[0] ? 4'h5 : 4'h6;
      repeat (2) begin
        tick();
        ds += int'(key_strobe);
      end
    end
    chk("toggle_strobes", ds, m_strobes - s0);
`ifdef KYPD_DEBOUNCE_EN
    chk("toggle_quiet", ds, 0);
`else
    repeat (3) tick();
`endif
    measure(4'h6, "settle6");
    measure(4'h9, "change9");

    // reset while an offer is pending
    hold(4'hE, 10);
    hold(4'h3, 10);
    hold(4'hF, 10);
    chk("offer_before_rst", 32'(out_valid), 1);
    pulse_reset();
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      nv += int'(out_valid);
    end
    chk("no_offer_after_rst", nv, 0);
    hold(4'hE, 10);
    hold(4'h5, 10);
    hold(4'hF, 10);
    chk("recommit_valid", 32'(out_valid), 1);
    chk("recommit_data", 32'(out_data), 32'h5);

    // random soak
    for (int s = 0; s < 60; s++) begin
      if ($urandom_range(0, 19) == 0) pulse_reset();
      key_code = 4'($urandom_range(0, 15));
      repeat ($urandom_range(1, 12)) begin
        out_ready = 1'($urandom_range(0, 1));
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
